ntt_stage_sequencer: RTL and testbench

- Control stage directly upstream of ntt_core; one instance drives one core.
- In IDLE it loads coefficient words from an external loader into the core memories.
- On start it sweeps every NTT stage (log_m = 1..STAGES), issuing read addresses, twiddle index i and delayed write-backs of the core results r1..r4.
- Inserts drain bubbles between stages so a stage never reads a word before the previous stage's write-back lands.

---
 rtl/ntt_stage_sequencer_if.sv | 43 ++++
 rtl/ntt_stage_sequencer.sv | 158 +++++++++++++++
 tb/tb_ntt_stage_sequencer.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ntt_stage_sequencer_if.sv
// Handshake, load and core-facing bus between the NTT stage sequencer and its
// loader/core. Master is the sequencer; slave is the loader/core side.
interface ntt_stage_sequencer_if #(
   parameter int ADDR_WIDTH = 9
);
   logic                  start;
   logic                  busy;
   logic                  done;
   logic                  load_valid;
   logic [ADDR_WIDTH-1:0] load_address;
   logic [59:0]           load_upper_data;
   logic [59:0]           load_lower_data;
   logic [3:0]            log_m;
   logic [9:0]            i;
   logic [ADDR_WIDTH-1:0] upper_read_address;
   logic [ADDR_WIDTH-1:0] lower_read_address;
   logic [1:0]            mode;
   logic                  write_enable;
   logic [ADDR_WIDTH-1:0] upper_write_address;
   logic [59:0]           upper_data_input;
   logic [ADDR_WIDTH-1:0] lower_write_address;
   logic [59:0]           lower_data_input;
   logic [29:0]           r1;
   logic [29:0]           r2;
   logic [29:0]           r3;
   logic [29:0]           r4;

   modport master (
      input  start, load_valid, load_address, load_upper_data, load_lower_data,
      input  r1, r2, r3, r4,
      output busy, done, log_m, i, upper_read_address, lower_read_address, mode,
      output write_enable, upper_write_address, upper_data_input,
      output lower_write_address, lower_data_input
   );

   modport slave (
      output start, load_valid, load_address, load_upper_data, load_lower_data,
      output r1, r2, r3, r4,
      input  busy, done, log_m, i, upper_read_address, lower_read_address, mode,
      input  write_enable, upper_write_address, upper_data_input,
      input  lower_write_address, lower_data_input
   );
endinterface

// File: rtl/ntt_stage_sequencer.sv
// Sweeps all NTT stages over one ntt_core: issues reads and twiddle indices,
// writes results back LATENCY cycles later, and passes loader writes through in IDLE.
module ntt_stage_sequencer #(
   parameter int ADDR_WIDTH   = 9,
   parameter int STAGES       = 10,
   parameter int LATENCY      = 3,
   parameter int MODE_COMPUTE = 0
) (
   input logic                   clk,
   input logic                   rst,
   ntt_stage_sequencer_if.master bus
);
   localparam int                     DRAIN_WIDTH = $clog2(LATENCY + 1);
   localparam logic [3:0]             LAST_STAGE  = 4'(STAGES);
   localparam logic [3:0]             SHIFT_BASE  = 4'(ADDR_WIDTH + 1);
   localparam logic [DRAIN_WIDTH-1:0] DRAIN_LOAD  = DRAIN_WIDTH'(LATENCY);

   typedef enum logic [1:0] {
      IDLE,
      READ,
      DRAIN,
      DONE
   } state_t;

   state_t                 state_reg, state_next;
   logic [ADDR_WIDTH-1:0]  a_reg, a_next;
   logic [3:0]             log_m_reg, log_m_next;
   logic [DRAIN_WIDTH-1:0] drain_reg, drain_next;

   logic                   wb_valid_pipe [LATENCY];
   logic [ADDR_WIDTH-1:0]  wb_addr_pipe  [LATENCY];

   logic [3:0]             i_shift;
   logic [ADDR_WIDTH-1:0] i_full;
   logic                   load_active;
   logic                   wb_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         a_reg     <= '0;
         log_m_reg <= '0;
         drain_reg <= '0;
      end else begin
         state_reg <= state_next;
         a_reg     <= a_next;
         log_m_reg <= log_m_next;
         drain_reg <= drain_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      a_next     = a_reg;
      log_m_next = log_m_reg;
      drain_next = drain_reg;
      case (state_reg)
         IDLE: begin
            if (bus.start) begin
               state_next = READ;
               log_m_next = 4'd1;
               a_next     = '0;
            end
         end
         READ: begin
            // a wraps to zero after the last word, ready for the next stage
            a_next = a_reg + 1'b1;
            if (a_reg == '1) begin
               state_next = DRAIN;
               drain_next = DRAIN_LOAD;
            end
         end
         DRAIN: begin
            if (drain_reg == DRAIN_WIDTH'(1)) begin
               if (log_m_reg < LAST_STAGE) begin
                  state_next = READ;
                  log_m_next = log_m_reg + 4'd1;
                  a_next     = '0;
               end else begin
                  state_next = DONE;
               end
            end else begin
               drain_next = drain_reg - 1'b1;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Write-back delay line: read address and its valid flag, LATENCY stages deep
   genvar gi;
   generate
      for (gi = 0; gi < LATENCY; gi++) begin : g_wb
         if (gi == 0) begin : g_head
            always_ff @(posedge clk) begin
               if (rst) begin
                  wb_valid_pipe[0] <= 1'b0;
                  wb_addr_pipe[0]  <= '0;
               end else begin
                  wb_valid_pipe[0] <= (state_reg == READ);
                  wb_addr_pipe[0]  <= a_reg;
               end
            end
         end else begin : g_tail
            always_ff @(posedge clk) begin
               if (rst) begin
                  wb_valid_pipe[gi] <= 1'b0;
                  wb_addr_pipe[gi]  <= '0;
               end else begin
                  wb_valid_pipe[gi] <= wb_valid_pipe[gi-1];
                  wb_addr_pipe[gi]  <= wb_addr_pipe[gi-1];
               end
            end
         end
      end
   endgenerate

   assign wb_valid    = wb_valid_pipe[LATENCY-1];
   assign load_active = (state_reg == IDLE) && bus.load_valid;

   // Later stages use more address bits as twiddle index; log_m=0 in IDLE shifts all out
   assign i_shift = SHIFT_BASE - log_m_reg;
   assign i_full  = a_reg >> i_shift;

   assign bus.busy               = (state_reg == READ) || (state_reg == DRAIN);
   assign bus.done               = (state_reg == DONE);
   assign bus.log_m              = log_m_reg;
   assign bus.i                  = 10'(i_full);
   assign bus.upper_read_address = a_reg;
   assign bus.lower_read_address = a_reg;
   assign bus.mode               = 2'(MODE_COMPUTE);

   always_comb begin
      bus.write_enable        = 1'b0;
      bus.upper_write_address = '0;
      bus.lower_write_address = '0;
      bus.upper_data_input    = '0;
      bus.lower_data_input    = '0;
      if (wb_valid) begin
         bus.write_enable        = 1'b1;
         bus.upper_write_address = wb_addr_pipe[LATENCY-1];
         bus.lower_write_address = wb_addr_pipe[LATENCY-1];
         bus.upper_data_input    = {bus.r2, bus.r1};
         bus.lower_data_input    = {bus.r4, bus.r3};
      end else if (load_active) begin
         bus.write_enable        = 1'b1;
         bus.upper_write_address = bus.load_address;
         bus.lower_write_address = bus.load_address;
         bus.upper_data_input    = bus.load_upper_data;
         bus.lower_data_input    = bus.load_lower_data;
      end
   end
endmodule

// File: tb/tb_ntt_stage_sequencer.sv
// Bench for ntt_stage_sequencer: two instances (3 stages / latency 2 and 1 stage /
// latency 1), table-driven load vectors and a per-cycle expected-output queue.
module tb_ntt_stage_sequencer;
   localparam int AW = 2;
   localparam logic [59:0] RU = {30'd6, 30'd5};
   localparam logic [59:0] RL = {30'd8, 30'd7};

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ntt_stage_sequencer_if #(.ADDR_WIDTH(AW)) bus_a ();
   ntt_stage_sequencer_if #(.ADDR_WIDTH(AW)) bus_b ();

   ntt_stage_sequencer #(.ADDR_WIDTH(AW), .STAGES(3), .LATENCY(2), .MODE_COMPUTE(0)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a)
   );

   ntt_stage_sequencer #(.ADDR_WIDTH(AW), .STAGES(1), .LATENCY(1), .MODE_COMPUTE(0)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   typedef struct {
      logic        busy;
      logic        done;
      logic [3:0]  log_m;
      logic        rd;
      logic [9:0]  i;
      logic [1:0]  ra_u;
      logic [1:0]  ra_l;
      logic        we;
      logic [1:0]  wa_u;
      logic [1:0]  wa_l;
      logic [59:0] ud;
      logic [59:0] ld;
      logic [1:0]  mode;
   } obs_t;

   typedef struct {
      logic [1:0]  addr;
      logic [59:0] ud;
      logic [59:0] ld;
      logic        exp_we;
      logic        exp_busy;
      logic [1:0]  exp_wa;
      logic [59:0] exp_ud;
      logic [59:0] exp_ld;
   } load_vec_t;

   int   tests_run    = 0;
   int   tests_failed = 0;
   obs_t exp_q[$];

   function automatic obs_t sample(input bit sel);
      obs_t o;
      if (!sel) begin
         o.busy = bus_a.busy;  o.done = bus_a.done;  o.log_m = bus_a.log_m;  o.i = bus_a.i;
         o.ra_u = bus_a.upper_read_address;  o.ra_l = bus_a.lower_read_address;
         o.we = bus_a.write_enable;  o.wa_u = bus_a.upper_write_address;
         o.wa_l = bus_a.lower_write_address;  o.ud = bus_a.upper_data_input;
         o.ld = bus_a.lower_data_input;  o.mode = bus_a.mode;
      end else begin
         o.busy = bus_b.busy;  o.done = bus_b.done;  o.log_m = bus_b.log_m;  o.i = bus_b.i;
         o.ra_u = bus_b.upper_read_address;  o.ra_l = bus_b.lower_read_address;
         o.we = bus_b.write_enable;  o.wa_u = bus_b.upper_write_address;
         o.wa_l = bus_b.lower_write_address;  o.ud = bus_b.upper_data_input;
         o.ld = bus_b.lower_data_input;  o.mode = bus_b.mode;
      end
      o.rd = 1'b0;
      return o;
   endfunction

   function automatic obs_t idle_obs(input logic [3:0] lm, input bit rd);
      obs_t o;
      o.busy = 1'b0;  o.done = 1'b0;  o.log_m = lm;  o.rd = rd;  o.i = '0;
      o.ra_u = '0;  o.ra_l = '0;  o.we = 1'b0;  o.wa_u = '0;  o.wa_l = '0;
      o.ud = '0;  o.ld = '0;  o.mode = 2'd0;
      return o;
   endfunction

   task automatic check(input string name, input obs_t g, input obs_t e);
      bit bad;
      bad = 1'b0;
      tests_run++;
      if (g.busy !== e.busy || g.done !== e.done || g.log_m !== e.log_m ||
          g.we !== e.we || g.mode !== e.mode) bad = 1'b1;
      if (e.rd && (g.ra_u !== e.ra_u || g.ra_l !== e.ra_l || g.i !== e.i)) bad = 1'b1;
      if (e.we && (g.wa_u !== e.wa_u || g.wa_l !== e.wa_l || g.ud !== e.ud || g.ld !== e.ld))
         bad = 1'b1;
      if (bad) begin
         tests_failed++;
         $display("FAIL %s: got busy=%0d done=%0d log_m=%0d i=%0d ra=%0d/%0d we=%0d wa=%0d/%0d ud=%h ld=%h mode=%0d; expected busy=%0d done=%0d log_m=%0d i=%0d ra=%0d we=%0d wa=%0d ud=%h ld=%h",
                  name, g.busy, g.done, g.log_m, g.i, g.ra_u, g.ra_l, g.we, g.wa_u, g.wa_l,
                  g.ud, g.ld, g.mode, e.busy, e.done, e.log_m, e.i, e.ra_u, e.we, e.wa_u,
                  e.ud, e.ld);
      end else begin
         $display("[TB] ok %s busy=%0d log_m=%0d i=%0d ra=%0d we=%0d wa=%0d done=%0d",
                  name, g.busy, g.log_m, g.i, g.ra_u, g.we, g.wa_u, g.done);
      end
   endtask

   task automatic check_int(input string name, input int got, input int exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end else begin
         $display("[TB] ok %s = %0d", name, got);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #2;
   endtask

   task automatic clear_inputs();
      bus_a.start = 1'b0;  bus_a.load_valid = 1'b0;  bus_a.load_address = '0;
      bus_a.load_upper_data = '0;  bus_a.load_lower_data = '0;
      bus_b.start = 1'b0;  bus_b.load_valid = 1'b0;  bus_b.load_address = '0;
      bus_b.load_upper_data = '0;  bus_b.load_lower_data = '0;
      rst = 1'b0;
   endtask

   // Timeline of one full run; index 0 is the cycle right after start is sampled
   task automatic build_run(input int stages, input int lat);
      obs_t tl[$];
      int   total;
      int   idx;
      total = stages * (4 + lat) + 2;
      for (int t = 0; t < total; t++) tl.push_back(idle_obs(4'(stages), 1'b0));
      idx = 0;
      for (int s = 1; s <= stages; s++) begin
         for (int a = 0; a < 4; a++) begin
            tl[idx].busy = 1'b1;  tl[idx].log_m = 4'(s);  tl[idx].rd = 1'b1;
            tl[idx].ra_u = 2'(a);  tl[idx].ra_l = 2'(a);
            tl[idx].i = 10'(a >> (AW + 1 - s));
            tl[idx + lat].we = 1'b1;  tl[idx + lat].wa_u = 2'(a);  tl[idx + lat].wa_l = 2'(a);
            tl[idx + lat].ud = RU;  tl[idx + lat].ld = RL;
            idx++;
         end
         for (int d = 0; d < lat; d++) begin
            tl[idx].busy = 1'b1;  tl[idx].log_m = 4'(s);
            idx++;
         end
      end
      tl[idx].done = 1'b1;
      foreach (tl[t]) exp_q.push_back(tl[t]);
   endtask

   // Pops one expectation per cycle; optional ignored-input pulse and reset at given indices
   task automatic run_queue(input bit sel, input string tag, input int pulse_at,
                            input int rst_at, output int done_at);
      obs_t e;
      obs_t g;
      int   n;
      done_at = -1;
      n = 0;
      while (exp_q.size() > 0) begin
         if (n == pulse_at) begin
            bus_a.start = 1'b1;  bus_a.load_valid = 1'b1;  bus_a.load_address = 2'd3;
            bus_a.load_upper_data = 60'hABC;  bus_a.load_lower_data = 60'hDEF;
         end
         if (n == rst_at) rst = 1'b1;
         #1;
         e = exp_q.pop_front();
         g = sample(sel);
         check($sformatf("%s[%0d]", tag, n), g, e);
         if (g.done === 1'b1 && done_at < 0) done_at = n + 1;
         next_cycle();
         clear_inputs();
         n++;
      end
   endtask

   load_vec_t load_tab[4];
   int        done_at;
   obs_t      e;

   initial begin
      load_tab[0] = '{2'd0, {30'd0, 30'd100}, {30'd0, 30'd200}, 1'b1, 1'b0, 2'd0, {30'd0, 30'd100}, {30'd0, 30'd200}};
      load_tab[1] = '{2'd1, {30'd0, 30'd101}, {30'd0, 30'd201}, 1'b1, 1'b0, 2'd1, {30'd0, 30'd101}, {30'd0, 30'd201}};
      load_tab[2] = '{2'd2, {30'd9, 30'd102}, {30'd0, 30'd202}, 1'b1, 1'b0, 2'd2, {30'd9, 30'd102}, {30'd0, 30'd202}};
      load_tab[3] = '{2'd3, {30'd0, 30'd103}, {30'd4, 30'd203}, 1'b1, 1'b0, 2'd3, {30'd0, 30'd103}, {30'd4, 30'd203}};

      clear_inputs();
      rst = 1'b1;
      bus_a.r1 = 30'd5;  bus_a.r2 = 30'd6;  bus_a.r3 = 30'd7;  bus_a.r4 = 30'd8;
      bus_b.r1 = 30'd5;  bus_b.r2 = 30'd6;  bus_b.r3 = 30'd7;  bus_b.r4 = 30'd8;
      next_cycle();
      next_cycle();
      rst = 1'b0;
      #1;
      check("reset_a", sample(1'b0), idle_obs(4'd0, 1'b1));
      check("reset_b", sample(1'b1), idle_obs(4'd0, 1'b1));
      next_cycle();

      // Loader writes pass straight through while idle
      for (int v = 0; v < 4; v++) begin
         bus_a.load_valid = 1'b1;  bus_a.load_address = load_tab[v].addr;
         bus_a.load_upper_data = load_tab[v].ud;  bus_a.load_lower_data = load_tab[v].ld;
         #1;
         e = idle_obs(4'd0, 1'b1);
         e.busy = load_tab[v].exp_busy;  e.we = load_tab[v].exp_we;
         e.wa_u = load_tab[v].exp_wa;  e.wa_l = load_tab[v].exp_wa;
         e.ud = load_tab[v].exp_ud;  e.ld = load_tab[v].exp_ld;
         check($sformatf("load[%0d]", v), sample(1'b0), e);
         next_cycle();
         clear_inputs();
      end
      #1;
      check("load_idle_after", sample(1'b0), idle_obs(4'd0, 1'b1));
      next_cycle();

      // Full run with start/load_valid pulsed during READ
      bus_a.start = 1'b1;
      next_cycle();
      clear_inputs();
      build_run(3, 2);
      run_queue(1'b0, "runA", 2, -1, done_at);
      check_int("runA_done_cycle", done_at, 19);

      // Reset during stage 2
      bus_a.start = 1'b1;
      next_cycle();
      clear_inputs();
      build_run(3, 2);
      while (exp_q.size() > 8) void'(exp_q.pop_back());
      for (int t = 0; t < 3; t++) exp_q.push_back(idle_obs(4'd0, 1'b1));
      run_queue(1'b0, "rstA", -1, 7, done_at);
      check_int("rstA_no_done", done_at, -1);

      bus_a.start = 1'b1;
      next_cycle();
      clear_inputs();
      build_run(3, 2);
      run_queue(1'b0, "freshA", -1, -1, done_at);
      check_int("freshA_done_cycle", done_at, 19);

      // Single stage, latency 1
      bus_b.start = 1'b1;
      next_cycle();
      clear_inputs();
      build_run(1, 1);
      run_queue(1'b1, "runB", -1, -1, done_at);
      check_int("runB_done_cycle", done_at, 6);

      // Load and start in the same idle cycle
      bus_a.start = 1'b1;  bus_a.load_valid = 1'b1;  bus_a.load_address = 2'd1;
      bus_a.load_upper_data = 60'h123;  bus_a.load_lower_data = 60'h456;
      #1;
      e = idle_obs(4'd3, 1'b0);
      e.we = 1'b1;  e.wa_u = 2'd1;  e.wa_l = 2'd1;  e.ud = 60'h123;  e.ld = 60'h456;
      check("load_start", sample(1'b0), e);
      next_cycle();
      clear_inputs();
      build_run(3, 2);
      run_queue(1'b0, "lsA", -1, -1, done_at);
      check_int("lsA_done_cycle", done_at, 19);

      // start and rst together: reset wins
      bus_a.start = 1'b1;
      rst = 1'b1;
      next_cycle();
      clear_inputs();
      #1;
      check("start_rst_0", sample(1'b0), idle_obs(4'd0, 1'b1));
      next_cycle();
      #1;
      check("start_rst_1", sample(1'b0), idle_obs(4'd0, 1'b1));
      next_cycle();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
